// File: rtl/sseg_arb_pkg.sv
// Shared types and config-word layout for the seven-segment display arbiter.
// The config word is {sign, mod_sel[1:0], dp_sel[1:0], dp_en, valid}.
package sseg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    ALARM = 2'd2
  } arb_state_e;

  localparam int CFG_W          = 7;
  localparam int CFG_VALID      = 0;
  localparam int CFG_DP_EN      = 1;
  localparam int CFG_DP_SEL_LO  = 2;
  localparam int CFG_MOD_SEL_LO = 4;
  localparam int CFG_SIGN       = 6;

  localparam logic [1:0] MOD_255  = 2'b00;
  localparam logic [1:0] MOD_2X99 = 2'b01;
  localparam logic [1:0] MOD_9999 = 2'b10;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set bit of mask strictly after start,
// wrapping around, with start itself considered last.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] mask,
  input  logic [IW-1:0]   start,
  output logic            found,
  output logic [IW-1:0]   idx
);

  // Scan from farthest to nearest so the nearest requester is written last and wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      found = found | mask[(int'(start) + 1 + k) % NREQ];
      idx   = mask[(int'(start) + 1 + k) % NREQ] ? IW'((int'(start) + 1 + k) % NREQ) : idx;
    end
  end

endmodule

// File: rtl/sseg_disp_arbiter.sv
// Shares one univ_sseg driver between NREQ clients: round-robin grants with a minimum
// dwell time, and client 0 as a preempting alarm channel that holds the display.
module sseg_disp_arbiter
  import sseg_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DWELL_CYC = 100000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [14*NREQ-1:0]   req_cnt1,
  input  logic [7*NREQ-1:0]    req_cnt2,
  input  logic [7*NREQ-1:0]    req_cfg,
  output logic [NREQ-1:0]      gnt,
  output logic [13:0]          cnt1,
  output logic [6:0]           cnt2,
  output logic                 valid,
  output logic                 dp_en,
  output logic [1:0]           dp_sel,
  output logic [1:0]           mod_sel,
  output logic                 sign
);

  localparam int IW = $clog2(NREQ);
  localparam int DW = $clog2(DWELL_CYC);
  localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL_CYC - 1);

  arb_state_e       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    rr_last_q, rr_last_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [13:0]      cnt1_q, cnt1_d;
  logic [6:0]       cnt2_q, cnt2_d;
  logic [CFG_W-1:0] cfg_q, cfg_d;

  logic             new_grant_s;
  logic             granted_s;
  logic [NREQ-1:0]  pick_mask_s;
  logic [IW-1:0]    pick_start_s;
  logic             pick_found_s;
  logic [IW-1:0]    pick_idx_s;

  // Masking with the current grant excludes the holder (and client 0 while in ALARM).
  assign pick_mask_s  = req & ~gnt_q;
  assign pick_start_s = (state_q == IDLE) ? rr_last_q : idx_q;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_rr_pick (
    .mask  (pick_mask_s),
    .start (pick_start_s),
    .found (pick_found_s),
    .idx   (pick_idx_s)
  );

  // Next-state, grant selection, dwell counter and payload mux.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rr_last_d   = rr_last_q;
    new_grant_s = 1'b0;
    granted_s   = 1'b1;
    gnt_d       = '0;
    cnt1_d      = cnt1_q;
    cnt2_d      = cnt2_q;
    cfg_d       = cfg_q;

    case (state_q)
      IDLE: begin
        if (req[0]) begin
          state_d = ALARM; idx_d = '0; new_grant_s = 1'b1;
        end else if (pick_found_s) begin
          state_d = SHOW; idx_d = pick_idx_s; new_grant_s = 1'b1;
        end else begin
          granted_s = 1'b0;
        end
      end
      SHOW: begin
        // Preempt outranks both release and dwell expiry.
        if (req[0]) begin
          state_d = ALARM; idx_d = '0; new_grant_s = 1'b1;
        end else if (!req[idx_q]) begin
          if (pick_found_s) begin
            idx_d = pick_idx_s; new_grant_s = 1'b1;
          end else begin
            state_d = IDLE; granted_s = 1'b0;
          end
        end else if ((dwell_q == '0) && pick_found_s) begin
          idx_d = pick_idx_s; new_grant_s = 1'b1;
        end else begin
          state_d = SHOW;
        end
      end
      ALARM: begin
        if (req[0]) begin
          state_d = ALARM;
        end else if (pick_found_s) begin
          state_d = SHOW; idx_d = pick_idx_s; new_grant_s = 1'b1;
        end else begin
          state_d = IDLE; granted_s = 1'b0;
        end
      end
      default: begin
        state_d = IDLE; granted_s = 1'b0;
      end
    endcase

    if (new_grant_s) begin
      rr_last_d = idx_d;
      dwell_d   = DWELL_LOAD;
    end else if (dwell_q != '0) begin
      dwell_d   = dwell_q - DW'(1);
    end else begin
      dwell_d   = dwell_q;
    end

    // Idle blanks to dashes but keeps the rest of the last payload.
    if (granted_s) begin
      gnt_d[idx_d] = 1'b1;
      cnt1_d       = req_cnt1[int'(idx_d) * 14 +: 14];
      cnt2_d       = req_cnt2[int'(idx_d) * 7 +: 7];
      cfg_d        = req_cfg[int'(idx_d) * 7 +: 7];
    end else begin
      cfg_d[CFG_VALID] = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      rr_last_q <= IW'(NREQ - 1);
      dwell_q   <= '0;
      gnt_q     <= '0;
      cnt1_q    <= '0;
      cnt2_q    <= '0;
      cfg_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rr_last_q <= rr_last_d;
      dwell_q   <= dwell_d;
      gnt_q     <= gnt_d;
      cnt1_q    <= cnt1_d;
      cnt2_q    <= cnt2_d;
      cfg_q     <= cfg_d;
    end
  end

  assign gnt     = gnt_q;
  assign cnt1    = cnt1_q;
  assign cnt2    = cnt2_q;
  assign valid   = cfg_q[CFG_VALID];
  assign dp_en   = cfg_q[CFG_DP_EN];
  assign dp_sel  = cfg_q[CFG_DP_SEL_LO +: 2];
  assign mod_sel = cfg_q[CFG_MOD_SEL_LO +: 2];
  assign sign    = cfg_q[CFG_SIGN];

endmodule

// File: tb/tb_sseg_disp_arbiter.sv
// Directed bench for sseg_disp_arbiter (NREQ=4, DWELL_CYC=4) with an expected-result queue.
module tb_sseg_disp_arbiter;
  import sseg_arb_pkg::*;

  typedef struct packed {
    logic [3:0]  gnt;
    logic [13:0] c1;
    logic [6:0]  c2;
    logic [6:0]  cfg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [55:0] req_cnt1;
  logic [27:0] req_cnt2;
  logic [27:0] req_cfg;
  logic [3:0]  gnt;
  logic [13:0] cnt1;
  logic [6:0]  cnt2;
  logic        valid, dp_en, sign;
  logic [1:0]  dp_sel, mod_sel;

  logic [13:0] c1 [4];
  logic [6:0]  c2 [4];
  logic [6:0]  cf [4];

  exp_t sb[$];
  exp_t last_e;
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  assign req_cnt1 = {c1[3], c1[2], c1[1], c1[0]};
  assign req_cnt2 = {c2[3], c2[2], c2[1], c2[0]};
  assign req_cfg  = {cf[3], cf[2], cf[1], cf[0]};

  sseg_disp_arbiter #(.NREQ(4), .DWELL_CYC(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_cnt1 (req_cnt1),
    .req_cnt2 (req_cnt2),
    .req_cfg  (req_cfg),
    .gnt      (gnt),
    .cnt1     (cnt1),
    .cnt2     (cnt2),
    .valid    (valid),
    .dp_en    (dp_en),
    .dp_sel   (dp_sel),
    .mod_sel  (mod_sel),
    .sign     (sign)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check_out();
    exp_t       e;
    logic [6:0] ocfg;
    e    = sb.pop_front();
    ocfg = {sign, mod_sel, dp_sel, dp_en, valid};
    checks++;
    assert (gnt === e.gnt) else begin
      errors++;
      $error("FAIL gnt step %0d: observed %b expected %b", step_no, gnt, e.gnt);
    end
    checks++;
    assert ({cnt1, cnt2, ocfg} === {e.c1, e.c2, e.cfg}) else begin
      errors++;
      $error("FAIL payload step %0d: observed cnt1=%0d cnt2=%0d cfg=%b expected cnt1=%0d cnt2=%0d cfg=%b",
             step_no, cnt1, cnt2, ocfg, e.c1, e.c2, e.cfg);
    end
  endtask

  // Drive req, queue the expected result (g = granted client, -1 = idle), check after the edge.
  task automatic step(input logic [3:0] r, input int g);
    exp_t e;
    req = r;
    if (g < 0) begin
      e        = last_e;
      e.gnt    = 4'b0000;
      e.cfg[0] = 1'b0;
    end else begin
      e.gnt = 4'b0001 << g;
      e.c1  = c1[g];
      e.c2  = c2[g];
      e.cfg = cf[g];
    end
    last_e = e;
    sb.push_back(e);
    step_no++;
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic check_reset_zero(input string tag);
    checks++;
    assert ({gnt, cnt1, cnt2, sign, mod_sel, dp_sel, dp_en, valid} === 36'd0) else begin
      errors++;
      $error("FAIL %s: observed gnt=%b cnt1=%0d cnt2=%0d valid=%b expected all zero",
             tag, gnt, cnt1, cnt2, valid);
    end
  endtask

  initial begin
    c1[0] = 14'd500; c1[1] = 14'd123; c1[2] = 14'd200; c1[3] = 14'd300;
    c2[0] = 7'd5;    c2[1] = 7'd15;   c2[2] = 7'd25;   c2[3] = 7'd35;
    cf[0] = {1'b0, MOD_9999, 2'b00, 1'b0, 1'b1};
    cf[1] = {1'b0, MOD_9999, 2'b00, 1'b0, 1'b1};
    cf[2] = {1'b1, MOD_2X99, 2'b01, 1'b1, 1'b1};
    cf[3] = {1'b0, MOD_255,  2'b10, 1'b1, 1'b1};
    last_e = '0;
    req    = 4'b0000;
    rst_n  = 1'b0;
    #3;
    check_reset_zero("reset_initial");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single client, then live tracking of a payload change.
    step(4'b0000, -1);
    step(4'b0010, 1);
    c1[1] = 14'd124;
    step(4'b0010, 1);
    step(4'b0010, 1);
    step(4'b0010, 1);
    step(4'b0010, 1);          // dwell expired, nobody else: keep

    // Rotation, each grant four cycles.
    repeat (4) step(4'b1110, 2);
    repeat (4) step(4'b1110, 3);
    repeat (4) step(4'b1110, 1);
    step(4'b1110, 2);
    step(4'b1110, 2);

    // Alarm preempts in the second dwell cycle and is never rotated.
    repeat (4) step(4'b1111, 0);
    repeat (2) step(4'b1001, 0);
    step(4'b1000, 3);

    // Release plus a new request: the newcomer is eligible.
    step(4'b0100, 2);
    // Release in the first dwell cycle with nobody else: idle, payload held.
    step(4'b0000, -1);
    step(4'b0000, -1);

    // Release, dwell expiry and alarm on the same edge: alarm wins.
    repeat (4) step(4'b0010, 1);
    step(4'b0001, 0);
    step(4'b0000, -1);

    // Reset mid-grant clears outputs asynchronously and restores rr order.
    step(4'b0100, 2);
    rst_n = 1'b0;
    #1;
    check_reset_zero("reset_mid_grant");
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    last_e = '0;
    step(4'b0000, -1);
    step(4'b1100, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
